// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Hazard controller for the five-stage core. It produces:
//     - EX operand forward selects (00 reg file, 01 aluOutM, 10 wbOut)
//     - decode branch-compare forwards from the memory stage
//     - stall/flush controls for load-use, branch-operand and mult/div hazards
//
//   Optional feature macro: HAZARD_MDU_EN
//     defined   : the multiply/divide occupancy FSM drives mduBusy and stallE,
//                 and suppresses flushE while the MDU holds execute.
//     undefined : no FSM is built, mduStartE is ignored, and mduBusy and stallE
//                 are 0. MDU_LATENCY is kept for interface compatibility.
//
//   Parameters
//     MDU_LATENCY  cycles the MDU occupies execute after a start (2..63)
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     rsD, rtD, branchD               decode sources, branch in decode
//     rsE, rtE                        execute sources
//     writeRegE/M/W, regWriteE/M/W    destination and write enable per stage
//     memToRegE/M                     load in execute / memory
//     mduStartE                       one-cycle mult/div start pulse
//     forwardAE/BE                    EX operand selects
//     forwardAD/BD                    decode branch operand from aluOutM
//     stallF/D/E, flushE              pipeline register controls
//     mduBusy                         multiply/divide in progress
// -----------------------------------------------------------------------------

// Per-source-operand hazard detection. One instance covers the rs path and
// one covers the rt path; the top ORs the stall contributions together.
module hazard_src_lane (
  input  logic [4:0] srcE,
  input  logic [4:0] srcD,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memToRegE,
  input  logic       memToRegM,
  output logic [1:0] fwdE,
  output logic       fwdD,
  output logic       ldUse,
  output logic       brHit
);
  logic srcENz, srcDNz;
  assign srcENz = (srcE != 5'd0);
  assign srcDNz = (srcD != 5'd0);

  // Memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    fwdE = 2'b00;
    if (srcENz && regWriteM && (writeRegM == srcE))
      fwdE = 2'b01;
    else if (srcENz && regWriteW && (writeRegW == srcE))
      fwdE = 2'b10;
  end

  assign fwdD  = srcDNz && regWriteM && (writeRegM == srcD);

  // The load's destination travels in rtE at this point of the pipeline.
  assign ldUse = memToRegE && (rtE != 5'd0) && (rtE == srcD);

  // A branch compares in decode: an ALU result still in execute, or a load
  // still in memory, cannot reach the comparator in time.
  assign brHit = (regWriteE && (writeRegE != 5'd0) && (writeRegE == srcD)) ||
                 (memToRegM && (writeRegM != 5'd0) && (writeRegM == srcD));
endmodule

module hazard_unit #(
  parameter int MDU_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memToRegE,
  input  logic       memToRegM,
  input  logic       mduStartE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       mduBusy
);
  localparam int NUM_SRC = 2;  // lane 0 = rs, lane 1 = rt
  localparam int CntW    = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;

  logic [NUM_SRC-1:0][4:0] srcE, srcD;
  logic [NUM_SRC-1:0][1:0] fwdE;
  logic [NUM_SRC-1:0]      fwdD, ldUse, brHit;

  assign srcE = {rtE, rsE};
  assign srcD = {rtD, rsD};

  for (genvar i = 0; i < NUM_SRC; i++) begin : gLane
    hazard_src_lane uLane (
      .srcE      (srcE[i]),
      .srcD      (srcD[i]),
      .rtE       (rtE),
      .writeRegE (writeRegE),
      .writeRegM (writeRegM),
      .writeRegW (writeRegW),
      .regWriteE (regWriteE),
      .regWriteM (regWriteM),
      .regWriteW (regWriteW),
      .memToRegE (memToRegE),
      .memToRegM (memToRegM),
      .fwdE      (fwdE[i]),
      .fwdD      (fwdD[i]),
      .ldUse     (ldUse[i]),
      .brHit     (brHit[i])
    );
  end

  logic lwStall, brStall, busy;
  assign lwStall = |ldUse;
  assign brStall = branchD && (|brHit);

`ifdef HAZARD_MDU_EN
  typedef enum logic {IDLE, BUSY} mduState_t;
  mduState_t       state;
  logic [CntW-1:0] cnt;

  // cnt is loaded with LATENCY-1 on the start edge and the FSM leaves BUSY
  // on the edge where cnt==1, giving exactly LATENCY-1 busy cycles.
  // Starts during BUSY (including its final cycle) are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (mduStartE) begin
          state <= BUSY;
          cnt   <= CntW'(MDU_LATENCY - 1);
        end
        BUSY: if (cnt == CntW'(1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt   <= cnt - CntW'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == BUSY);
`else
  logic [CntW:0] unusedMdu;
  assign unusedMdu = {mduStartE, CntW'(MDU_LATENCY)};
  assign busy      = 1'b0;
`endif

  // All outputs read 0 while reset is held, including the combinational ones.
  assign forwardAE = rst_n ? fwdE[0] : 2'b00;
  assign forwardBE = rst_n ? fwdE[1] : 2'b00;
  assign forwardAD = rst_n && fwdD[0];
  assign forwardBD = rst_n && fwdD[1];
  assign stallF    = rst_n && (lwStall || brStall || busy);
  assign stallD    = stallF;
  assign stallE    = rst_n && busy;
  // While the MDU holds execute the ID/EX register is frozen, so no bubble;
  // the decode hazard is simply re-evaluated once busy drops.
  assign flushE    = rst_n && (lwStall || brStall) && !busy;
  assign mduBusy   = rst_n && busy;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MDU_LATENCY=4. MDU expectations follow
// HAZARD_MDU_EN so the same bench covers both builds.
module tb_hazard_unit;
`ifdef HAZARD_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       branchD, regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, mduStartE;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, stallF, stallD, stallE, flushE, mduBusy;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MDU_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .writeRegM(writeRegM),
    .writeRegW(writeRegW), .regWriteE(regWriteE), .regWriteM(regWriteM),
    .regWriteW(regWriteW), .memToRegE(memToRegE), .memToRegM(memToRegM),
    .mduStartE(mduStartE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD), .stallF(stallF),
    .stallD(stallD), .stallE(stallE), .flushE(flushE), .mduBusy(mduBusy)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stall/flush bundle: {stallF, stallD, stallE, flushE}
  task automatic chkCtl(input string tag, input logic [3:0] exp);
    #1 chk(tag, {stallF, stallD, stallE, flushE}, exp);
  endtask

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
    {branchD, regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, mduStartE} = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    // Reset: hazard-triggering inputs must still give all-zero outputs.
    regWriteM = 1; writeRegM = 5; rsE = 5; rtE = 5; rsD = 5;
    memToRegE = 1; mduStartE = 1;
    cyc(); cyc();
    #1;
    chk("rst_fwdAE", {2'b0, forwardAE}, 4'h0);
    chk("rst_fwdBE", {2'b0, forwardBE}, 4'h0);
    chk("rst_fwdAD", {3'b0, forwardAD}, 4'h0);
    chkCtl("rst_ctl", 4'b0000);
    chk("rst_busy", {3'b0, mduBusy}, 4'h0);
    clr();
    @(negedge clk); rst_n = 1;
    cyc();

    // Forwarding priority and fall-through.
    regWriteM = 1; writeRegM = 5; regWriteW = 1; writeRegW = 5; rsE = 5; rtE = 5;
    #1 chk("fwd_MW_A", {2'b0, forwardAE}, 4'h1);
    chk("fwd_MW_B", {2'b0, forwardBE}, 4'h1);
    regWriteM = 0;
    #1 chk("fwd_W_A", {2'b0, forwardAE}, 4'h2);
    chk("fwd_W_B", {2'b0, forwardBE}, 4'h2);
    rsE = 0; rtE = 0;
    #1 chk("fwd_r0_A", {2'b0, forwardAE}, 4'h0);
    chk("fwd_r0_B", {2'b0, forwardBE}, 4'h0);
    regWriteM = 1; writeRegM = 5; writeRegW = 6; rsE = 5; rtE = 6;
    #1 chk("fwd_split_A", {2'b0, forwardAE}, 4'h1);
    chk("fwd_split_B", {2'b0, forwardBE}, 4'h2);
    regWriteW = 0;
    #1 chk("fwd_noWen_B", {2'b0, forwardBE}, 4'h0);
    clr();

    // Decode branch forwards.
    regWriteM = 1; writeRegM = 7; rsD = 7; rtD = 9;
    #1 chk("fwdD_A", {3'b0, forwardAD}, 4'h1);
    chk("fwdD_B", {3'b0, forwardBD}, 4'h0);
    rtD = 7;
    #1 chk("fwdD_B_hit", {3'b0, forwardBD}, 4'h1);
    writeRegM = 0; rsD = 0; rtD = 0;
    #1 chk("fwdD_r0", {2'b0, forwardAD, forwardBD}, 4'h0);
    clr();

    // Load-use.
    memToRegE = 1; rtE = 8; rsD = 8;
    chkCtl("lw_rs", 4'b1101);
    rsD = 1; rtD = 8;
    chkCtl("lw_rt", 4'b1101);
    rtE = 0; rtD = 0; rsD = 0;
    chkCtl("lw_r0", 4'b0000);
    rtE = 8; rsD = 8;
    cyc();
    memToRegE = 0;
    chkCtl("lw_clear", 4'b0000);
    clr();

    // Branch operand hazards.
    branchD = 1; rsD = 3; regWriteE = 1; writeRegE = 3;
    chkCtl("br_E", 4'b1101);
    branchD = 0;
    chkCtl("br_nobranch", 4'b0000);
    branchD = 1; regWriteE = 0; writeRegE = 0; regWriteM = 1; writeRegM = 3;
    chkCtl("br_M_alu", 4'b0000);
    #1 chk("br_M_fwdAD", {3'b0, forwardAD}, 4'h1);
    memToRegM = 1;
    chkCtl("br_M_load", 4'b1101);
    clr();
    branchD = 1; regWriteE = 1; writeRegE = 0;
    chkCtl("br_r0", 4'b0000);
    // Simultaneous load-use and branch hazard: still a single stall/flush.
    clr();
    branchD = 1; rsD = 4; rtD = 6; regWriteE = 1; writeRegE = 4; memToRegE = 1; rtE = 6;
    chkCtl("lw_br_both", 4'b1101);
    clr();

    // MDU occupancy: start sampled at the end of cycle 0.
    mduStartE = 1;
    cyc();                                 // cycle 1
    mduStartE = 0;
    #1 chk("mdu_c1_busy", {3'b0, mduBusy}, {3'b0, MDU});
    chkCtl("mdu_c1_ctl", {MDU, MDU, MDU, 1'b0});
    mduStartE = 1;                         // ignored start in cycle 2
    cyc();                                 // cycle 2
    #1 chk("mdu_c2_busy", {3'b0, mduBusy}, {3'b0, MDU});
    cyc();                                 // cycle 3 (final busy cycle)
    #1 chk("mdu_c3_busy", {3'b0, mduBusy}, {3'b0, MDU});
    memToRegE = 1; rtE = 8; rsD = 8;       // load-use while busy: no bubble
    chkCtl("mdu_c3_lw", {1'b1, 1'b1, MDU, ~MDU});
    cyc();                                 // cycle 4
    mduStartE = 0;
    #1 chk("mdu_c4_busy", {3'b0, mduBusy}, 4'h0);
    chkCtl("mdu_c4_lw", 4'b1101);
    clr();
    cyc();                                 // cycle 5: final-cycle start was dropped
    #1 chk("mdu_c5_busy", {3'b0, mduBusy}, 4'h0);

    // Reset in the middle of BUSY.
    mduStartE = 1;
    cyc();
    mduStartE = 0;
    cyc();                                 // busy cycle 2
    regWriteM = 1; writeRegM = 5; rsE = 5;
    rst_n = 0;
    #1 chk("rstmid_busy", {3'b0, mduBusy}, 4'h0);
    chkCtl("rstmid_ctl", 4'b0000);
    chk("rstmid_fwd", {2'b0, forwardAE}, 4'h0);
    clr();
    @(negedge clk); rst_n = 1;
    cyc();
    #1 chk("rstrel_busy1", {3'b0, mduBusy}, 4'h0);
    cyc();
    #1 chk("rstrel_busy2", {3'b0, stallE, mduBusy}, 4'h0);
    mduStartE = 1;
    cyc();
    mduStartE = 0;
    #1 chk("restart_busy", {3'b0, mduBusy}, {3'b0, MDU});
    repeat (4) cyc();
    #1 chk("restart_done", {3'b0, mduBusy}, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
